// File: rtl/cle_serial_capture_pkg.sv
// Shared types and constants for the CLE309 serial-line capture block.
// Defines the FSM state, the address-window decode and a counter-width helper.
package cle_cap_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } cap_state_e;

    // Serial-device read window: BA13=0, BA12=1
    localparam logic CLE_WIN_BA13 = 1'b0;
    localparam logic CLE_WIN_BA12 = 1'b1;

    // Bits needed to hold the values 0..n-1 (never less than one bit)
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cle_serial_capture_if.sv
// Host-side word stream of the serial capture block (valid/ready handshake).
// master = word producer, slave = host consumer.
interface cle_serial_capture_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/cle_serial_capture_idle_timer.sv
// Idle timer for partial frames: counts enabled cycles since the last clear
// and pulses expired in the TIMEOUT-th consecutive idle cycle.
module cle_idle_timer
    import cle_cap_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CW   = cnt_w(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        expired = en && !clr && (cnt_q == LAST);
        if (clr || !en || expired) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cle_serial_capture.sv
// Captures the wired SDRD/p12 serial line on qualified bus reads, assembles
// DATA_W-bit words and offers them to the host with overrun and resync tracking.
module cle_serial_capture
    import cle_cap_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bus_strb,
    input  logic                 sser_n,
    input  logic                 ba13,
    input  logic                 ba12,
    input  logic                 br_w,
    input  logic                 sdrd,
    cle_serial_capture_if.master host,
    output logic                 ovf,
    input  logic                 ovf_clr,
    output logic [7:0]           resync_cnt,
    output logic                 busy
);

    localparam int            BW       = cnt_w(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    cap_state_e        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        resync_q, resync_d;
    logic              busy_q, busy_d;

    logic              cap;
    logic              expired;
    logic              complete;
    logic              drop;
    logic [DATA_W-1:0] shifted;

    cle_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cap),
        .en      (state_q == SHIFT),
        .expired (expired)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        resync_d    = resync_q;
        complete    = 1'b0;
        drop        = 1'b0;

        cap = bus_strb && !sser_n && (ba13 == CLE_WIN_BA13)
              && (ba12 == CLE_WIN_BA12) && br_w;

        if (MSB_FIRST) begin
            shifted = {shift_q[DATA_W-2:0], sdrd};
        end else begin
            shifted = {sdrd, shift_q[DATA_W-1:1]};
        end

        // A capture in the expiry cycle takes priority over the resync
        if (cap) begin
            if (bit_cnt_q == LAST_BIT) begin
                complete  = 1'b1;
                shift_d   = '0;
                bit_cnt_d = '0;
                state_d   = IDLE;
            end else begin
                shift_d   = shifted;
                bit_cnt_d = bit_cnt_q + BW'(1);
                state_d   = SHIFT;
            end
        end else if (expired) begin
            shift_d   = '0;
            bit_cnt_d = '0;
            state_d   = IDLE;
            if (resync_q != 8'hFF) begin
                resync_d = resync_q + 8'd1;
            end
        end

        // Holding register: a pop in the completion cycle frees room for the new word
        if (complete) begin
            if (!out_valid_q || host.out_ready) begin
                out_data_d  = shifted;
                out_valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (out_valid_q && host.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end

        busy_d = (state_d == SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            resync_q    <= 8'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            resync_q    <= resync_d;
            busy_q      <= busy_d;
        end
    end

    assign host.out_data  = out_data_q;
    assign host.out_valid = out_valid_q;
    assign ovf            = ovf_q;
    assign resync_cnt     = resync_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_cle_serial_capture.sv
// Bench for cle_serial_capture: MSB-first and LSB-first instances share stimulus
// and are compared against a queue-based frame model.
module tb_cle_serial_capture;

    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bus_strb = 1'b0, sser_n = 1'b1, ba13 = 1'b0, ba12 = 1'b0, br_w = 1'b0;
    logic sdrd = 1'b0, out_ready = 1'b0, ovf_clr = 1'b0;
    logic ovf_m, ovf_l, busy_m, busy_l;
    logic [7:0] resync_m, resync_l;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit         mq[$];
    int         idle_cnt;
    logic [7:0] e_data_m, e_data_l;
    logic       e_valid, e_ovf;
    int         e_resync;

    logic pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    cle_serial_capture_if #(.DATA_W(8)) if_m ();
    cle_serial_capture_if #(.DATA_W(8)) if_l ();
    assign if_m.out_ready = out_ready;
    assign if_l.out_ready = out_ready;

    cle_serial_capture #(.DATA_W(8), .MSB_FIRST(1'b1), .TIMEOUT(TIMEOUT)) dut_m (
        .clk(clk), .rst_n(rst_n), .bus_strb(bus_strb), .sser_n(sser_n), .ba13(ba13),
        .ba12(ba12), .br_w(br_w), .sdrd(sdrd), .host(if_m), .ovf(ovf_m),
        .ovf_clr(ovf_clr), .resync_cnt(resync_m), .busy(busy_m)
    );

    cle_serial_capture #(.DATA_W(8), .MSB_FIRST(1'b0), .TIMEOUT(TIMEOUT)) dut_l (
        .clk(clk), .rst_n(rst_n), .bus_strb(bus_strb), .sser_n(sser_n), .ba13(ba13),
        .ba12(ba12), .br_w(br_w), .sdrd(sdrd), .host(if_l), .ovf(ovf_l),
        .ovf_clr(ovf_clr), .resync_cnt(resync_l), .busy(busy_l)
    );

    task automatic model_reset();
        mq.delete();
        idle_cnt = 0;
        e_data_m = 8'h00;
        e_data_l = 8'h00;
        e_valid  = 1'b0;
        e_ovf    = 1'b0;
        e_resync = 0;
    endtask

    // Drive one clock of inputs, advance the model, return at posedge+1
    task automatic step(input logic strb, input logic sser, input logic a13, input logic a12,
                        input logic w, input logic d, input logic rdy, input logic clr);
        logic       cap, done, drop;
        logic [7:0] wm, wl;
        bus_strb = strb; sser_n = sser; ba13 = a13; ba12 = a12; br_w = w;
        sdrd = d; out_ready = rdy; ovf_clr = clr;
        cap  = strb & ~sser & ~a13 & a12 & w;
        done = 1'b0;
        wm   = 8'h00;
        wl   = 8'h00;
        if (cap) begin
            mq.push_back(d);
            idle_cnt = 0;
            if (mq.size() == 8) begin
                for (int i = 0; i < 8; i++) begin
                    wm = wm | (8'(mq[i]) << (7 - i));
                    wl = wl | (8'(mq[i]) << i);
                end
                mq.delete();
                done = 1'b1;
            end
        end else if (mq.size() != 0) begin
            idle_cnt++;
            if (idle_cnt == TIMEOUT) begin
                mq.delete();
                idle_cnt = 0;
                if (e_resync < 255) e_resync++;
            end
        end
        drop = done && e_valid && !rdy;
        if (done && !drop) begin
            e_data_m = wm;
            e_data_l = wl;
            e_valid  = 1'b1;
        end else if (!done && e_valid && rdy) begin
            e_valid = 1'b0;
        end
        if (drop) e_ovf = 1'b1;
        else if (clr) e_ovf = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic cap_bit(input logic d, input logic rdy, input logic clr);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, d, rdy, clr);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), rdy, 1'b0);
    endtask

    task automatic send_word(input logic [7:0] w, input logic last_rdy, input logic last_clr);
        for (int i = 0; i < 8; i++)
            cap_bit(w[7-i], (i == 7) ? last_rdy : 1'b0, (i == 7) ? last_clr : 1'b0);
    endtask

    task automatic test_reset();
        vectors++;
        if ({if_m.out_valid, if_m.out_data, ovf_m, resync_m, busy_m} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_m: got valid=%b data=%h ovf=%b resync=%0d busy=%b, want all 0",
                     if_m.out_valid, if_m.out_data, ovf_m, resync_m, busy_m);
        end
        vectors++;
        if ({if_l.out_valid, if_l.out_data, ovf_l, resync_l, busy_l} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_l: got valid=%b data=%h ovf=%b resync=%0d busy=%b, want all 0",
                     if_l.out_valid, if_l.out_data, ovf_l, resync_l, busy_l);
        end
        $display("test_reset: outputs after reset checked");
    endtask

    task automatic test_msb_lsb();
        for (int i = 0; i < 8; i++) begin
            cap_bit(pat[i], 1'b0, 1'b0);
            if (i == 6) begin
                vectors++;
                if (if_m.out_valid !== 1'b0 || busy_m !== 1'b1) begin
                    miscompares++;
                    $display("FAIL early_valid: got valid=%b busy=%b, want valid=0 busy=1",
                             if_m.out_valid, busy_m);
                end
            end
        end
        vectors++;
        if (if_m.out_valid !== 1'b1 || if_m.out_data !== 8'hB2 || busy_m !== 1'b0) begin
            miscompares++;
            $display("FAIL msb_word: got valid=%b data=%h busy=%b, want 1 B2 0",
                     if_m.out_valid, if_m.out_data, busy_m);
        end
        vectors++;
        if (if_l.out_valid !== 1'b1 || if_l.out_data !== 8'h4D) begin
            miscompares++;
            $display("FAIL lsb_word: got valid=%b data=%h, want 1 4D", if_l.out_valid, if_l.out_data);
        end
        idle(1'b1);
        vectors++;
        if (if_m.out_valid !== 1'b0 || if_m.out_data !== 8'hB2) begin
            miscompares++;
            $display("FAIL pop: got valid=%b data=%h, want 0 B2", if_m.out_valid, if_m.out_data);
        end
        $display("test_msb_lsb: msb=%h lsb=%h", e_data_m, e_data_l);
    endtask

    task automatic test_ignored();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ~pat[i], 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, ~pat[i], 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, ~pat[i], 1'b0, 1'b0);
            cap_bit(pat[i], 1'b0, 1'b0);
        end
        vectors++;
        if (if_m.out_valid !== 1'b1 || if_m.out_data !== 8'hB2 || resync_m !== 8'd0) begin
            miscompares++;
            $display("FAIL ignored: got valid=%b data=%h resync=%0d, want 1 B2 0",
                     if_m.out_valid, if_m.out_data, resync_m);
        end
        idle(1'b1);
        $display("test_ignored: word %h with interleaved non-qualified strobes", e_data_m);
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 3; i++) cap_bit(pat[i], 1'b0, 1'b0);
        for (int i = 0; i < TIMEOUT - 1; i++) idle(1'b0);
        vectors++;
        if (busy_m !== 1'b1 || resync_m !== 8'd0) begin
            miscompares++;
            $display("FAIL pre_timeout: got busy=%b resync=%0d, want 1 0", busy_m, resync_m);
        end
        idle(1'b0);
        vectors++;
        if (busy_m !== 1'b0 || resync_m !== 8'd1 || resync_l !== 8'd1) begin
            miscompares++;
            $display("FAIL timeout: got busy=%b resync=%0d/%0d, want 0 1", busy_m, resync_m, resync_l);
        end
        for (int i = 0; i < 8; i++) cap_bit(pat[i], 1'b0, 1'b0);
        vectors++;
        if (if_m.out_data !== 8'hB2 || if_m.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL after_resync: got data=%h valid=%b, want B2 1", if_m.out_data, if_m.out_valid);
        end
        idle(1'b1);
        for (int i = 0; i < 3; i++) cap_bit(pat[i], 1'b0, 1'b0);
        for (int i = 0; i < TIMEOUT - 1; i++) idle(1'b0);
        cap_bit(pat[3], 1'b0, 1'b0);
        vectors++;
        if (busy_m !== 1'b1 || resync_m !== 8'd1) begin
            miscompares++;
            $display("FAIL cap_at_limit: got busy=%b resync=%0d, want 1 1", busy_m, resync_m);
        end
        for (int i = 4; i < 8; i++) cap_bit(pat[i], 1'b0, 1'b0);
        vectors++;
        if (if_m.out_data !== 8'hB2 || resync_m !== 8'd1) begin
            miscompares++;
            $display("FAIL limit_word: got data=%h resync=%0d, want B2 1", if_m.out_data, resync_m);
        end
        idle(1'b1);
        $display("test_timeout: resync=%0d", e_resync);
    endtask

    task automatic test_overflow();
        send_word(8'hB2, 1'b0, 1'b0);
        send_word(8'h11, 1'b0, 1'b0);
        vectors++;
        if (if_m.out_data !== 8'hB2 || if_m.out_valid !== 1'b1 || ovf_m !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow: got data=%h valid=%b ovf=%b, want B2 1 1",
                     if_m.out_data, if_m.out_valid, ovf_m);
        end
        vectors++;
        if (if_l.out_data !== 8'h4D || ovf_l !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_l: got data=%h ovf=%b, want 4D 1", if_l.out_data, ovf_l);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (ovf_m !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clr: got ovf=%b, want 0", ovf_m);
        end
        send_word(8'h11, 1'b0, 1'b1);
        vectors++;
        if (ovf_m !== 1'b1 || if_m.out_data !== 8'hB2) begin
            miscompares++;
            $display("FAIL clr_vs_set: got ovf=%b data=%h, want 1 B2", ovf_m, if_m.out_data);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        $display("test_overflow: ovf=%b held=%h", e_ovf, e_data_m);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            cap_bit(1'((8'h11 >> (7 - i)) & 8'h01), (i == 7), 1'b0);
            vectors++;
            if (if_m.out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL valid_continuous: bit %0d got valid=%b, want 1", i, if_m.out_valid);
            end
        end
        vectors++;
        if (if_m.out_data !== 8'h11 || if_l.out_data !== 8'h88 || ovf_m !== 1'b0) begin
            miscompares++;
            $display("FAIL pop_push: got data=%h/%h ovf=%b, want 11/88 0",
                     if_m.out_data, if_l.out_data, ovf_m);
        end
        idle(1'b1);
        $display("test_back_to_back: msb=%h lsb=%h", e_data_m, e_data_l);
    endtask

    task automatic test_random();
        int sel;
        for (int n = 0; n < 800; n++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 2) begin
                for (int k = 0; k < int'($urandom_range(TIMEOUT - 2, TIMEOUT + 1)); k++)
                    idle(1'($urandom_range(0, 1)));
            end else if (sel < 50) begin
                cap_bit(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
            end else if (sel < 75) begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
            end else begin
                idle(1'($urandom_range(0, 1)));
            end
            vectors++;
            if (if_m.out_valid !== e_valid || if_m.out_data !== e_data_m || if_l.out_data !== e_data_l) begin
                miscompares++;
                $display("FAIL rand_word @%0d: got valid=%b data=%h/%h, want %b %h/%h", n,
                         if_m.out_valid, if_m.out_data, if_l.out_data, e_valid, e_data_m, e_data_l);
            end
            vectors++;
            if (ovf_m !== e_ovf || resync_m !== 8'(e_resync) || busy_m !== (mq.size() != 0)) begin
                miscompares++;
                $display("FAIL rand_flags @%0d: got ovf=%b resync=%0d busy=%b, want %b %0d %b", n,
                         ovf_m, resync_m, busy_m, e_ovf, e_resync, (mq.size() != 0));
            end
        end
        $display("test_random: final resync=%0d ovf=%b", e_resync, e_ovf);
    endtask

    task automatic test_async_reset();
        send_word(8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cap_bit(pat[i], 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({if_m.out_valid, if_m.out_data, ovf_m, resync_m, busy_m} !== 19'd0) begin
            miscompares++;
            $display("FAIL async_reset: got valid=%b data=%h ovf=%b resync=%0d busy=%b, want all 0",
                     if_m.out_valid, if_m.out_data, ovf_m, resync_m, busy_m);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < TIMEOUT + 2; i++) idle(1'b0);
        vectors++;
        if (resync_m !== 8'd0 || busy_m !== 1'b0 || if_m.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset: got resync=%0d busy=%b valid=%b, want 0 0 0",
                     resync_m, busy_m, if_m.out_valid);
        end
        $display("test_async_reset: partial frame discarded without resync");
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_msb_lsb();
        test_ignored();
        test_timeout();
        test_overflow();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
